dmem_arbiter: RTL

Shares the single data-memory port between the pipeline's memory stage (CPU port) and an external requester such as a program loader or debug master (EXT port). Memory reads are synchronous with one-cycle latency, so the block sequences each access, stalls the pipeline while a CPU access is waiting or its load data is in flight, and bounds EXT starvation with an aging counter. It sits between the EX/MEM pipeline register and the data memory, and its stall output drives the pipeline register enables.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter_wait_counter.sv | 24 ++
 rtl/dmem_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port ids.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_RD_CPU = 2'd1,
      ARB_RD_EXT = 2'd2
   } arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_EXT = 1;
   localparam int NUM_PORTS = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, EXT and memory-side signals around the data-memory arbiter.
interface dmem_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             cpu_req;
   logic             cpu_we;
   logic [WIDTH-1:0] cpu_addr;
   logic [WIDTH-1:0] cpu_wdata;
   logic             cpu_stall;
   logic [WIDTH-1:0] cpu_rdata;
   logic             cpu_rvalid;

   logic             ext_req;
   logic             ext_we;
   logic [WIDTH-1:0] ext_addr;
   logic [WIDTH-1:0] ext_wdata;
   logic             ext_gnt;
   logic [WIDTH-1:0] ext_rdata;
   logic             ext_rvalid;

   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wd;
   logic [WIDTH-1:0] mem_rd;

   // Arbiter side.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      input  mem_rd,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_we, mem_addr, mem_wd
   );

   // Requester / memory side.
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ext_req, ext_we, ext_addr, ext_wdata,
      output mem_rd,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_we, mem_addr, mem_wd
   );

endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating EXT aging counter; at_max forces EXT priority over the CPU.
module arb_wait_counter #(
   parameter  int MAX_WAIT = 4,
   localparam int CW       = $clog2(MAX_WAIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (inc && (count != CW'(MAX_WAIT)))
         count <= count + CW'(1);
   end

   assign at_max = (count == CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single synchronous data-memory port between the CPU memory
// stage and an external requester, stalling the pipeline around CPU loads.
module dmem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 4
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   arb_state_t           state;
   logic                 cpuElig;
   logic                 extWins;
   logic                 atMax;
   logic                 cpuLoad;
   logic                 extRead;
   logic [NUM_PORTS-1:0] gnt;

   // A CPU request seen while its load returns is the one already served.
   always_comb begin
      cpuElig = bus.cpu_req && (state != ARB_RD_CPU);
      extWins = bus.ext_req && (!cpuElig || atMax);
      gnt     = '0;
      if (!reset) begin
         gnt[PORT_EXT] = extWins;
         gnt[PORT_CPU] = cpuElig && !extWins;
      end
   end

   assign cpuLoad = gnt[PORT_CPU] && !bus.cpu_we;
   assign extRead = gnt[PORT_EXT] && !bus.ext_we;

   always_comb begin
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_wd   = '0;
      if (gnt[PORT_CPU]) begin
         bus.mem_we   = bus.cpu_we;
         bus.mem_addr = bus.cpu_addr;
         bus.mem_wd   = bus.cpu_wdata;
      end else if (gnt[PORT_EXT]) begin
         bus.mem_we   = bus.ext_we;
         bus.mem_addr = bus.ext_addr;
         bus.mem_wd   = bus.ext_wdata;
      end
   end

   // Stall while the CPU loses arbitration, and for the issue cycle of a load.
   assign bus.cpu_stall  = !reset && cpuElig && (!gnt[PORT_CPU] || !bus.cpu_we);
   assign bus.ext_gnt    = gnt[PORT_EXT];

   assign bus.cpu_rvalid = !reset && (state == ARB_RD_CPU);
   assign bus.ext_rvalid = !reset && (state == ARB_RD_EXT);
   assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rd : '0;
   assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_rd : '0;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ARB_IDLE;
      else if (cpuLoad)
         state <= ARB_RD_CPU;
      else if (extRead)
         state <= ARB_RD_EXT;
      else
         state <= ARB_IDLE;
   end

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) uWait (
      .clk    (clk),
      .reset  (reset),
      .inc    (bus.ext_req && !gnt[PORT_EXT]),
      .clr    (!bus.ext_req || gnt[PORT_EXT]),
      .at_max (atMax)
   );

   a_oneGrant : assert property (@(posedge clk) !(gnt[PORT_CPU] && gnt[PORT_EXT]));

endmodule
